// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller between read ports A and B and write port W.
// A has fixed priority. B and W alternate through a round-robin pointer.
// One transaction is open at a time.
// Ports:
//   clk, rst - clock and synchronous active-high reset.
//   a_*, b_* - read clients. Inputs: request, address, burst length. Outputs: available, data, done.
//   w_*      - write client. Inputs: request, address, mask, burst length, data. Output: done.
//   ram_*    - controller side: request/address/length/mask out, available/data/done in.
//   timeout_error - sticky flag, set when a transaction is aborted for running too long.
module sdram_arbiter #(
    parameter int ADDR_WIDTH     = 23,
    parameter int BURST_WIDTH    = 9,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_rd_request,
    input  logic [ADDR_WIDTH-1:0]  a_rd_address,
    input  logic [BURST_WIDTH-1:0] a_rd_burst_length,
    output logic                   a_rd_available,
    output logic [31:0]            a_rd_data,
    output logic                   a_done,
    input  logic                   b_rd_request,
    input  logic [ADDR_WIDTH-1:0]  b_rd_address,
    input  logic [BURST_WIDTH-1:0] b_rd_burst_length,
    output logic                   b_rd_available,
    output logic [31:0]            b_rd_data,
    output logic                   b_done,
    input  logic                   w_request,
    input  logic [ADDR_WIDTH-1:0]  w_address,
    input  logic [3:0]             w_mask,
    input  logic [BURST_WIDTH-1:0] w_burst_length,
    input  logic [31:0]            w_data,
    output logic                   w_done,
    output logic                   ram_rd_request,
    output logic [ADDR_WIDTH-1:0]  ram_rd_address,
    output logic [BURST_WIDTH-1:0] ram_rd_burst_length,
    input  logic                   ram_rd_available,
    input  logic [31:0]            ram_rd_data,
    output logic                   ram_wr_request,
    output logic [ADDR_WIDTH-1:0]  ram_wr_address,
    output logic [3:0]             ram_wr_mask,
    output logic [BURST_WIDTH-1:0] ram_wr_burst_length,
    output logic [31:0]            ram_wr_data,
    input  logic                   ram_wr_done,
    output logic                   timeout_error
);
    typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR} state_t;
    typedef enum logic [1:0] {OWN_A, OWN_B, OWN_W} owner_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t                 r_state, w_next;
    owner_t                 r_owner, w_pick;
    logic                   r_a_pend, r_b_pend, r_w_pend;
    logic [ADDR_WIDTH-1:0]  r_a_addr, r_b_addr, r_w_addr;
    logic [BURST_WIDTH-1:0] r_a_len, r_b_len, r_w_len;
    logic [3:0]             r_w_mask;
    logic                   r_rr_w;
    logic                   r_seen;
    logic [CW-1:0]          r_cnt;
    logic                   w_take_a, w_take_b, w_take_w;
    logic                   w_grant, w_wait, w_ok, w_timeout, w_finish, w_fwd;
    assign ram_wr_data = w_data;
    // A client that is pending or being served ignores further requests.
    // In its done cycle the arbiter is already IDLE, so a new request is accepted.
    always_comb begin
        w_take_a  = a_rd_request && !r_a_pend && !(r_state != IDLE && r_owner == OWN_A);
        w_take_b  = b_rd_request && !r_b_pend && !(r_state != IDLE && r_owner == OWN_B);
        w_take_w  = w_request && !r_w_pend && !(r_state != IDLE && r_owner == OWN_W);
        w_grant   = r_state == IDLE && (r_a_pend || r_b_pend || r_w_pend);
        w_pick    = r_a_pend ? OWN_A : (r_w_pend && (!r_b_pend || r_rr_w)) ? OWN_W : OWN_B;
        w_wait    = r_state == WAIT_RD || r_state == WAIT_WR;
        // A read burst ends on the first low available after at least one high one.
        w_ok      = r_state == WAIT_RD ? (r_seen && !ram_rd_available) : (r_state == WAIT_WR && ram_wr_done);
        w_timeout = w_wait && r_cnt == CW'(TIMEOUT_CYCLES - 1);
        w_finish  = w_wait && (w_ok || w_timeout);
        w_fwd     = r_state == WAIT_RD && ram_rd_available;
        w_next    = r_state;
        case (r_state)
            IDLE:     w_next = !w_grant ? IDLE : (w_pick == OWN_W ? ISSUE_WR : ISSUE_RD);
            ISSUE_RD: w_next = WAIT_RD;
            ISSUE_WR: w_next = WAIT_WR;
            default:  w_next = w_finish ? IDLE : r_state;
        endcase
    end
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    always_ff @(posedge clk) begin
        if (w_take_a) begin
            r_a_addr <= a_rd_address;
            r_a_len  <= a_rd_burst_length;
        end
        if (w_take_b) begin
            r_b_addr <= b_rd_address;
            r_b_len  <= b_rd_burst_length;
        end
        if (w_take_w) begin
            r_w_addr <= w_address;
            r_w_len  <= w_burst_length;
            r_w_mask <= w_mask;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_pend            <= 1'b0;
            r_b_pend            <= 1'b0;
            r_w_pend            <= 1'b0;
            r_owner             <= OWN_A;
            r_rr_w              <= 1'b0;
            r_seen              <= 1'b0;
            r_cnt               <= '0;
            ram_rd_request      <= 1'b0;
            ram_rd_address      <= '0;
            ram_rd_burst_length <= '0;
            ram_wr_request      <= 1'b0;
            ram_wr_address      <= '0;
            ram_wr_mask         <= '0;
            ram_wr_burst_length <= '0;
            a_rd_available      <= 1'b0;
            a_rd_data           <= '0;
            a_done              <= 1'b0;
            b_rd_available      <= 1'b0;
            b_rd_data           <= '0;
            b_done              <= 1'b0;
            w_done              <= 1'b0;
            timeout_error       <= 1'b0;
        end else begin
            r_a_pend <= w_take_a || (r_a_pend && !(w_grant && w_pick == OWN_A));
            r_b_pend <= w_take_b || (r_b_pend && !(w_grant && w_pick == OWN_B));
            r_w_pend <= w_take_w || (r_w_pend && !(w_grant && w_pick == OWN_W));
            if (w_grant) begin
                r_owner <= w_pick;
                // After a B or W grant the pointer favours the other one.
                r_rr_w  <= w_pick == OWN_B ? 1'b1 : (w_pick == OWN_W ? 1'b0 : r_rr_w);
                if (w_pick == OWN_W) begin
                    ram_wr_address      <= r_w_addr;
                    ram_wr_burst_length <= r_w_len;
                    ram_wr_mask         <= r_w_mask;
                end else begin
                    ram_rd_address      <= w_pick == OWN_A ? r_a_addr : r_b_addr;
                    ram_rd_burst_length <= w_pick == OWN_A ? r_a_len : r_b_len;
                end
            end
            ram_rd_request <= r_state == ISSUE_RD;
            ram_wr_request <= r_state == ISSUE_WR;
            r_seen         <= r_state == WAIT_RD && !w_finish && (r_seen || ram_rd_available);
            r_cnt          <= (w_wait && !w_finish) ? r_cnt + 1'b1 : '0;
            timeout_error  <= timeout_error || (w_timeout && !w_ok);
            a_done         <= w_finish && r_owner == OWN_A;
            b_done         <= w_finish && r_owner == OWN_B;
            w_done         <= w_finish && r_owner == OWN_W;
            a_rd_available <= w_fwd && r_owner == OWN_A;
            a_rd_data      <= (w_fwd && r_owner == OWN_A) ? ram_rd_data : '0;
            b_rd_available <= w_fwd && r_owner == OWN_B;
            b_rd_data      <= (w_fwd && r_owner == OWN_B) ? ram_rd_data : '0;
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench with a small behavioural SDRAM controller model.
module tb_sdram_arbiter;
    localparam int AW = 23;
    localparam int BW = 9;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_rd_request = 1'b0, b_rd_request = 1'b0, w_request = 1'b0;
    logic [AW-1:0] a_rd_address = '0, b_rd_address = '0, w_address = '0;
    logic [BW-1:0] a_rd_burst_length = '0, b_rd_burst_length = '0, w_burst_length = '0;
    logic [3:0]    w_mask = '0;
    logic [31:0]   w_data = '0;
    logic          a_rd_available, b_rd_available, a_done, b_done, w_done;
    logic [31:0]   a_rd_data, b_rd_data;
    logic          ram_rd_request, ram_wr_request, timeout_error;
    logic [AW-1:0] ram_rd_address, ram_wr_address;
    logic [BW-1:0] ram_rd_burst_length, ram_wr_burst_length;
    logic [3:0]    ram_wr_mask;
    logic [31:0]   ram_wr_data;
    logic          ram_rd_available, ram_wr_done;
    logic [31:0]   ram_rd_data;
    always #5 clk = ~clk;
    sdram_arbiter #(.ADDR_WIDTH(AW), .BURST_WIDTH(BW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .a_rd_request(a_rd_request), .a_rd_address(a_rd_address), .a_rd_burst_length(a_rd_burst_length),
        .a_rd_available(a_rd_available), .a_rd_data(a_rd_data), .a_done(a_done),
        .b_rd_request(b_rd_request), .b_rd_address(b_rd_address), .b_rd_burst_length(b_rd_burst_length),
        .b_rd_available(b_rd_available), .b_rd_data(b_rd_data), .b_done(b_done),
        .w_request(w_request), .w_address(w_address), .w_mask(w_mask), .w_burst_length(w_burst_length),
        .w_data(w_data), .w_done(w_done),
        .ram_rd_request(ram_rd_request), .ram_rd_address(ram_rd_address), .ram_rd_burst_length(ram_rd_burst_length),
        .ram_rd_available(ram_rd_available), .ram_rd_data(ram_rd_data),
        .ram_wr_request(ram_wr_request), .ram_wr_address(ram_wr_address), .ram_wr_mask(ram_wr_mask),
        .ram_wr_burst_length(ram_wr_burst_length), .ram_wr_data(ram_wr_data), .ram_wr_done(ram_wr_done),
        .timeout_error(timeout_error)
    );
    // Controller model: read data starts 3 edges after the request, len+1 words of {addr[15:0], index}.
    // With stuck set, available never falls. Write done pulses len+3 edges after the request.
    int rd_dly, rd_left, rd_idx, wr_dly;
    bit stuck = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            rd_dly <= 0; rd_left <= 0; rd_idx <= 0; wr_dly <= 0;
            ram_rd_available <= 1'b0; ram_rd_data <= '0; ram_wr_done <= 1'b0;
        end else begin
            ram_rd_available <= !ram_rd_request && rd_dly == 0 && rd_left > 0;
            ram_rd_data      <= {ram_rd_address[15:0], 16'(rd_idx)};
            ram_wr_done      <= !ram_wr_request && wr_dly == 1;
            if (ram_rd_request) begin
                rd_dly <= 2; rd_left <= int'(ram_rd_burst_length) + 1; rd_idx <= 0;
            end else if (rd_dly > 0) rd_dly <= rd_dly - 1;
            else if (rd_left > 0) begin
                rd_left <= stuck ? rd_left : rd_left - 1;
                rd_idx  <= rd_idx + 1;
            end
            if (ram_wr_request) wr_dly <= int'(ram_wr_burst_length) + 3;
            else if (wr_dly > 0) wr_dly <= wr_dly - 1;
        end
    end
    // Event counters sampled on the falling edge. seq logs done owners, 2 bits each: A=1, B=2, W=3.
    int n_rdreq = 0, n_wrreq = 0, n_both = 0, n_a_av = 0, n_b_av = 0;
    int n_a_done = 0, n_b_done = 0, n_w_done = 0, n_a_align = 0, n_dones = 0;
    logic [31:0] a_sum = '0, b_sum = '0;
    logic [15:0] seq = '0;
    logic pa = 1'b0;
    always @(negedge clk) begin
        if (rst) pa <= 1'b0;
        else begin
            n_rdreq   <= n_rdreq + int'(ram_rd_request);
            n_wrreq   <= n_wrreq + int'(ram_wr_request);
            n_both    <= n_both + int'(ram_rd_request && ram_wr_request);
            n_a_av    <= n_a_av + int'(a_rd_available);
            n_b_av    <= n_b_av + int'(b_rd_available);
            n_a_done  <= n_a_done + int'(a_done);
            n_b_done  <= n_b_done + int'(b_done);
            n_w_done  <= n_w_done + int'(w_done);
            n_a_align <= n_a_align + int'(a_done && pa);
            if (a_done || b_done || w_done) begin
                seq     <= {seq[13:0], a_done ? 2'd1 : (b_done ? 2'd2 : 2'd3)};
                n_dones <= n_dones + 1;
            end
            if (a_rd_available) a_sum <= a_sum + a_rd_data;
            if (b_rd_available) b_sum <= b_sum + b_rd_data;
            pa <= a_rd_available;
        end
    end
    int n_checks = 0, n_err = 0;
    int s_rdreq, s_wrreq, s_a_av, s_b_av, s_a_done, s_b_done, s_w_done, s_a_align, s_dones;
    logic [31:0] s_a_sum, s_b_sum;
    logic held;
    int cyc;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        a_rd_request = 1'b0;
        b_rd_request = 1'b0;
        w_request    = 1'b0;
    endtask
    task automatic set_a(input logic [AW-1:0] ad, input logic [BW-1:0] ln);
        a_rd_request = 1'b1; a_rd_address = ad; a_rd_burst_length = ln;
    endtask
    task automatic set_b(input logic [AW-1:0] ad, input logic [BW-1:0] ln);
        b_rd_request = 1'b1; b_rd_address = ad; b_rd_burst_length = ln;
    endtask
    task automatic set_w(input logic [AW-1:0] ad, input logic [3:0] mk, input logic [BW-1:0] ln);
        w_request = 1'b1; w_address = ad; w_mask = mk; w_burst_length = ln;
    endtask
    task automatic snap();
        s_rdreq = n_rdreq; s_wrreq = n_wrreq; s_a_av = n_a_av; s_b_av = n_b_av;
        s_a_done = n_a_done; s_b_done = n_b_done; s_w_done = n_w_done;
        s_a_align = n_a_align; s_dones = n_dones; s_a_sum = a_sum; s_b_sum = b_sum;
    endtask
    task automatic wait_dones(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_dones < target; i++) step();
        check(tag, n_dones, target);
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_rd_request", ram_rd_request, 0);
        check("rst_ram_wr_request", ram_wr_request, 0);
        check("rst_dones", {a_done, b_done, w_done}, 0);
        check("rst_avail", {a_rd_available, b_rd_available}, 0);
        check("rst_timeout_error", timeout_error, 0);
        check("rst_addr", {ram_rd_address, ram_wr_address, ram_wr_mask}, 0);
        rst = 1'b0;
        step();
        // Single A read, length 3
        snap();
        set_a(23'h000400, 9'd3);
        step();
        step();
        check("a1_no_req_early", ram_rd_request, 0);
        step();
        check("a1_req", ram_rd_request, 1);
        check("a1_addr", ram_rd_address, 23'h000400);
        check("a1_len", ram_rd_burst_length, 3);
        step();
        check("a1_req_one_cycle", ram_rd_request, 0);
        check("a1_addr_held", ram_rd_address, 23'h000400);
        wait_dones(s_dones + 1, 40, "a1_done_seen");
        check("a1_words", n_a_av - s_a_av, 4);
        check("a1_data_sum", a_sum - s_a_sum, 32'h1000_0006);
        check("a1_a_done", n_a_done - s_a_done, 1);
        check("a1_done_align", n_a_align - s_a_align, 1);
        check("a1_b_quiet", n_b_av - s_b_av, 0);
        check("a1_one_ram_req", n_rdreq - s_rdreq, 1);
        // A, B and W requested together
        snap();
        set_a(23'h000010, 9'd1);
        set_b(23'h000020, 9'd1);
        set_w(23'h000030, 4'hF, 9'd1);
        step();
        wait_dones(s_dones + 3, 80, "abw_done_seen");
        check("abw_order", seq[5:0], 6'b01_10_11);
        check("abw_b_sum", b_sum - s_b_sum, 32'h0040_0001);
        check("abw_b_words", n_b_av - s_b_av, 2);
        // Lone B, then B and W together: pointer now favours W
        snap();
        set_b(23'h000040, 9'd0);
        step();
        wait_dones(s_dones + 1, 40, "rr_lone_b_seen");
        set_b(23'h000050, 9'd0);
        set_w(23'h000060, 4'hF, 9'd0);
        step();
        wait_dones(s_dones + 3, 80, "rr_pair_seen");
        check("rr_order", seq[5:0], 6'b10_11_10);
        // A priority: B then A become pending during a write, A wins; A re-requested in its done cycle loses to B
        snap();
        set_w(23'h000070, 4'hF, 9'd4);
        step();
        set_b(23'h000080, 9'd0);
        step();
        set_a(23'h000090, 9'd0);
        step();
        for (int i = 0; i < 60 && !a_done; i++) step();
        check("prio_a_done_seen", a_done, 1);
        set_a(23'h0000a0, 9'd0);
        step();
        wait_dones(s_dones + 4, 80, "prio_done_seen");
        check("prio_order", seq[7:0], 8'b11_01_10_01);
        // Write, mask 0101, length 2
        snap();
        w_data = 32'hCAFE_F00D;
        set_w(23'h012340, 4'b0101, 9'd2);
        step();
        for (int i = 0; i < 20 && !ram_wr_request; i++) step();
        check("wr_req", ram_wr_request, 1);
        check("wr_addr", ram_wr_address, 23'h012340);
        check("wr_mask", ram_wr_mask, 4'b0101);
        check("wr_len", ram_wr_burst_length, 2);
        check("wr_data_pass", ram_wr_data, 32'hCAFE_F00D);
        held = 1'b1;
        for (int i = 0; i < 30 && !ram_wr_done; i++) begin
            step();
            held &= (ram_wr_address == 23'h012340) && (ram_wr_mask == 4'b0101);
        end
        check("wr_fields_held", held, 1);
        check("wr_ram_done_seen", ram_wr_done, 1);
        check("wr_w_done_not_yet", w_done, 0);
        step();
        check("wr_w_done", w_done, 1);
        step();
        check("wr_w_done_pulse", w_done, 0);
        // Duplicate B request while B is in service
        snap();
        set_b(23'h000800, 9'd2);
        step();
        for (int i = 0; i < 10 && !ram_rd_request; i++) step();
        set_b(23'h000900, 9'd2);
        step();
        wait_dones(s_dones + 1, 40, "dup_done_seen");
        repeat (15) step();
        check("dup_one_ram_req", n_rdreq - s_rdreq, 1);
        check("dup_one_b_done", n_b_done - s_b_done, 1);
        // B re-requested in its own done cycle
        snap();
        set_b(23'h000a00, 9'd1);
        step();
        for (int i = 0; i < 40 && !b_done; i++) step();
        check("rereq_b_done_seen", b_done, 1);
        set_b(23'h000b00, 9'd1);
        step();
        wait_dones(s_dones + 2, 40, "rereq_done_seen");
        check("rereq_two_ram_req", n_rdreq - s_rdreq, 2);
        check("rereq_b_sum", b_sum - s_b_sum, 32'h2A00_0002);
        // Timeout: available never falls, B waiting behind
        snap();
        stuck = 1'b1;
        set_a(23'h000c00, 9'd0);
        step();
        for (int i = 0; i < 10 && !ram_rd_request; i++) step();
        check("to_flag_before", timeout_error, 0);
        set_b(23'h000d00, 9'd0);
        cyc = 0;
        for (int i = 0; i < 60 && !a_done; i++) begin
            step();
            cyc++;
        end
        stuck = 1'b0;
        check("to_cycles", cyc, 16);
        check("to_a_done", a_done, 1);
        check("to_flag", timeout_error, 1);
        wait_dones(s_dones + 2, 40, "to_b_done_seen");
        check("to_b_served", n_b_av - s_b_av, 1);
        check("to_flag_sticky", timeout_error, 1);
        // Reset in the middle of a write
        snap();
        set_w(23'h000e00, 4'hF, 9'd8);
        step();
        for (int i = 0; i < 10 && !ram_wr_request; i++) step();
        repeat (3) step();
        check("rstw_in_wait", ram_wr_address, 23'h000e00);
        rst = 1'b1;
        step();
        check("rstw_wr_fields", {ram_wr_request, ram_wr_address, ram_wr_mask, ram_wr_burst_length}, 0);
        check("rstw_rd_fields", {ram_rd_request, ram_rd_address, ram_rd_burst_length}, 0);
        check("rstw_dones", {a_done, b_done, w_done, a_rd_available, b_rd_available}, 0);
        check("rstw_timeout_clr", timeout_error, 0);
        rst = 1'b0;
        repeat (20) step();
        check("rstw_no_w_done", n_w_done - s_w_done, 0);
        check("no_rd_wr_overlap", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
